// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between two producers: one-entry skid buffers
// per requester, round-robin drain into a registered write stage, plus RAW hazard flags.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b
);

  logic              buf0_v;
  logic [ADDR_W-1:0] buf0_addr;
  logic [DATA_W-1:0] buf0_data;
  logic              buf1_v;
  logic [ADDR_W-1:0] buf1_addr;
  logic [DATA_W-1:0] buf1_data;
  logic              rr;

  logic              grant0;
  logic              grant1;
  logic              grant_any;
  logic              grant_zero;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic              accept0;
  logic              accept1;

  always_comb begin
    grant0     = buf0_v && (!buf1_v || !rr);
    grant1     = buf1_v && !grant0;
    grant_any  = grant0 || grant1;
    grant_addr = grant1 ? buf1_addr : buf0_addr;
    grant_data = grant1 ? buf1_data : buf0_data;
    grant_zero = ZERO_REG && (grant_addr == '0);
  end

  // A buffer being drained this cycle can be refilled on the same edge.
  assign req0_ready = !rst && (!buf0_v || grant0);
  assign req1_ready = !rst && (!buf1_v || grant1);
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_v    <= 1'b0;
      buf0_addr <= '0;
      buf0_data <= '0;
    end else if (accept0) begin
      buf0_v    <= 1'b1;
      buf0_addr <= req0_addr;
      buf0_data <= req0_data;
    end else if (grant0) begin
      buf0_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf1_v    <= 1'b0;
      buf1_addr <= '0;
      buf1_data <= '0;
    end else if (accept1) begin
      buf1_v    <= 1'b1;
      buf1_addr <= req1_addr;
      buf1_data <= req1_data;
    end else if (grant1) begin
      buf1_v    <= 1'b0;
    end
  end

  // Granted side is rr under contention, so flipping hands priority to the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (buf0_v && buf1_v) begin
      rr <= ~rr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant_any && !grant_zero) begin
      rf_we    <= 1'b1;
      rf_waddr <= grant_addr;
      rf_wdata <= grant_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  function automatic logic pending(input logic [ADDR_W-1:0] ra);
    logic hit;
    hit = (buf0_v && (buf0_addr == ra)) ||
          (buf1_v && (buf1_addr == ra)) ||
          (rf_we  && (rf_waddr  == ra));
    return hit && !(ZERO_REG && (ra == '0));
  endfunction

  always_comb begin
    hazard_a = pending(rd_addr_a);
    hazard_b = pending(rd_addr_b);
  end

endmodule
